// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter granting four requesters write access to one shared register,
// with a release timeout that raises a sticky error flag.
module shared_reg_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] wr_data,
    output logic [3:0]         gnt,
    output logic               ack,
    output logic [WIDTH-1:0]   reg_q,
    output logic [1:0]         owner,
    output logic               busy,
    output logic               err
);
    typedef enum logic [1:0] {IDLE, GRANT, WRITE, RELEASE} state_t;
    localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);
    state_t     state, state_n;
    logic [1:0] ptr, win, pick;
    logic [7:0] cnt;
    logic       timeout;
    // Scan downward so the nearest requester after ptr is the last, winning assignment.
    always_comb begin
        pick = ptr;
        for (int k = 4; k >= 1; k--)
            if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
    end
    assign timeout = state == RELEASE && req[win] && cnt == TLIM;
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = |req ? GRANT : IDLE;
            GRANT:   state_n = WRITE;
            WRITE:   state_n = RELEASE;
            RELEASE: state_n = (!req[win] || timeout) ? IDLE : RELEASE;
        endcase
    end
    always_comb begin
        busy = state != IDLE;
        gnt  = busy ? 4'b0001 << win : 4'b0000;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            win   <= '0;
            ptr   <= 2'd3;
            cnt   <= '0;
            ack   <= 1'b0;
            reg_q <= '0;
            owner <= '0;
            err   <= 1'b0;
        end else begin
            ack <= state == WRITE;
            cnt <= state == RELEASE ? cnt + 8'd1 : 8'd0;
            if (state == IDLE && |req) win <= pick;
            if (state == WRITE) begin
                reg_q <= wr_data[win*WIDTH +: WIDTH];
                owner <= win;
                ptr   <= win;
            end
            if (timeout) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed and randomized transactions checked against a
// transaction-level round-robin model of the shared register arbiter.
module tb_shared_reg_arbiter;
    localparam int W  = 8;
    localparam int TO = 15;
    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     req;
    logic [4*W-1:0] wr_data;
    logic [3:0]     gnt;
    logic           ack;
    logic [W-1:0]   reg_q;
    logic [1:0]     owner;
    logic           busy;
    logic           err;
    int n_chk = 0;
    int n_fail = 0;
    int m_ptr = 3;
    logic [W-1:0] m_reg = '0;
    int m_owner = 0;
    logic m_err = 1'b0;

    shared_reg_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .wr_data(wr_data), .gnt(gnt),
        .ack(ack), .reg_q(reg_q), .owner(owner), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input int p, input logic [3:0] r);
        for (int d = 1; d <= 4; d++)
            if (r[(p + d) % 4]) return (p + d) % 4;
        return -1;
    endfunction

    // One full grant/write/release cycle; hold = cycles the winner keeps req after ack.
    task automatic txn(input logic [3:0] mask, input int hold, input bit pulse, input logic [4*W-1:0] wd);
        int w, x;
        logic [3:0] wb;
        w  = rr(m_ptr, mask);
        wb = 4'(1 << w);
        req = mask;
        wr_data = $urandom;
        tick();
        chk("grant", gnt, wb);
        chk("busy_grant", busy, 1);
        chk("ack_grant", ack, 0);
        if (pulse) req = 4'b0000;
        wr_data = $urandom;
        tick();
        chk("gnt_write", gnt, wb);
        chk("reg_before_write", reg_q, m_reg);
        chk("ack_write", ack, 0);
        wr_data = wd;
        tick();
        m_reg = wd[w*W +: W];
        m_owner = w;
        m_ptr = w;
        chk("ack_pulse", ack, 1);
        chk("reg_q", reg_q, m_reg);
        chk("owner", owner, m_owner);
        chk("gnt_release", gnt, wb);
        if (pulse) hold = 0;
        x = (hold + 1 < TO) ? hold + 1 : TO;
        for (int j = 1; j <= x; j++) begin
            req = ((j <= hold) ? wb : 4'b0000) | (4'($urandom) & ~wb);
            wr_data = $urandom;
            tick();
            if (j < x) begin
                chk("gnt_held", gnt, wb);
                chk("ack_once", ack, 0);
            end
        end
        if (hold >= TO) m_err = 1'b1;
        req = 4'b0000;
        chk("gnt_dropped", gnt, 0);
        chk("busy_idle", busy, 0);
        chk("err", err, m_err);
        chk("reg_stable", reg_q, m_reg);
    endtask

    initial begin
        reset = 1'b1;
        req = 4'b0000;
        wr_data = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_reg", reg_q, 0);
        chk("rst_owner", owner, 0);
        tick();
        chk("idle_no_req", gnt, 0);
        txn(4'b0100, 0, 1'b0, 32'h00A5_0000);
        for (int i = 0; i < 5; i++) txn(4'b1111, 0, 1'b0, 32'h1312_1110);
        txn(4'b0010, 2, 1'b0, $urandom);
        txn(4'b0011, 0, 1'b0, $urandom);
        txn(4'b0011, 0, 1'b0, $urandom);
        txn(4'b1000, 14, 1'b0, $urandom);
        chk("no_err_at_14", err, 0);
        txn(4'b1000, 20, 1'b0, $urandom);
        txn(4'b0001, 0, 1'b0, $urandom);
        chk("err_sticky", err, 1);
        // Reset lands while the write is in flight.
        req = 4'b0001;
        wr_data = 32'h0000_003C;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b0000;
        m_ptr = 3;
        m_reg = '0;
        m_owner = 0;
        m_err = 1'b0;
        chk("midwrite_reg", reg_q, 0);
        chk("midwrite_gnt", gnt, 0);
        chk("midwrite_ack", ack, 0);
        chk("midwrite_err", err, 0);
        txn(4'b0001, 0, 1'b0, 32'h0000_003C);
        txn(4'b0100, 0, 1'b1, $urandom);
        for (int i = 0; i < 40; i++) begin
            logic [3:0] m;
            m = 4'($urandom_range(1, 15));
            txn(m, $urandom_range(0, 20), $urandom_range(0, 7) == 0, $urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
